// File: rtl/bch_nand_packer_if.sv
// Signal bundle between the BCH encoder output stage, the packer and the NAND write controller.
// The packer sits on the slave side; the driver of the codeword stream uses master.
interface bch_nand_packer_if #(
  parameter int BITS      = 1,
  parameter int BUS_WIDTH = 8
);
  logic                 ce;
  logic [BITS-1:0]      enc_data;
  logic                 enc_first;
  logic                 enc_last;
  logic                 enc_data_bits;
  logic                 enc_ecc_bits;
  logic [BUS_WIDTH-1:0] out_data;
  logic                 out_valid;
  logic                 out_ready;
  logic                 out_last;
  logic                 out_ecc;
  logic                 hold;
  logic                 overflow;
  logic                 frame_err;

  modport master (
    output ce, enc_data, enc_first, enc_last, enc_data_bits, enc_ecc_bits, out_ready,
    input  out_data, out_valid, out_last, out_ecc, hold, overflow, frame_err
  );

  modport slave (
    input  ce, enc_data, enc_first, enc_last, enc_data_bits, enc_ecc_bits, out_ready,
    output out_data, out_valid, out_last, out_ecc, hold, overflow, frame_err
  );
endinterface

// File: rtl/bch_nand_packer.sv
// Packs BITS-wide BCH codeword chunks LSB-first into BUS_WIDTH-bit NAND words and queues
// them in a small FIFO; partial final words are padded with 1s (erased NAND state).
module bch_nand_packer #(
  parameter int BITS       = 1,
  parameter int BUS_WIDTH  = 8,
  parameter int FIFO_DEPTH = 4
) (
  input logic              clk,
  input logic              rst_n,
  bch_nand_packer_if.slave bus
);
  localparam int N    = BUS_WIDTH / BITS;
  localparam int CW   = (N > 1) ? $clog2(N) : 1;
  localparam int AW   = $clog2(FIFO_DEPTH);
  localparam int CNTW = AW + 1;
  localparam int EW   = BUS_WIDTH + 2;

  typedef enum logic [0:0] {IDLE, COLLECT} state_t;

  state_t               state_reg, state_next;
  logic [BUS_WIDTH-1:0] word_reg, word_next;
  logic [CW-1:0]        cnt_reg, cnt_next;
  logic                 ecc_reg, ecc_next;
  logic                 frame_err_reg, frame_err_next;

  logic                 chunk, restart, take, word_full, cur_ecc;
  logic [CW-1:0]        k;
  logic [BUS_WIDTH-1:0] assembled;
  logic                 push, push_last;

  assign chunk     = bus.ce & (bus.enc_data_bits | bus.enc_ecc_bits);
  assign restart   = chunk & bus.enc_first;
  assign take      = chunk & (restart | (state_reg == COLLECT));
  // A restarting chunk always lands in slot 0, whatever was pending.
  assign k         = (restart || state_reg == IDLE) ? '0 : cnt_reg;
  assign word_full = (k == CW'(N - 1));
  assign cur_ecc   = (restart ? 1'b0 : ecc_reg) | bus.enc_ecc_bits;

  // Slots below k keep collected chunks, slot k takes the new chunk, slots above read as
  // erased (all ones) so a word closed early by enc_last comes out already padded.
  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_slot
      assign assembled[gi*BITS +: BITS] =
          (CW'(gi) < k)  ? word_reg[gi*BITS +: BITS] :
          (CW'(gi) == k) ? bus.enc_data : {BITS{1'b1}};
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      word_reg      <= '0;
      cnt_reg       <= '0;
      ecc_reg       <= 1'b0;
      frame_err_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      word_reg      <= word_next;
      cnt_reg       <= cnt_next;
      ecc_reg       <= ecc_next;
      frame_err_reg <= frame_err_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    word_next      = word_reg;
    cnt_next       = cnt_reg;
    ecc_next       = ecc_reg;
    frame_err_next = frame_err_reg;
    push           = 1'b0;
    push_last      = 1'b0;
    if (take) begin
      if (restart && state_reg == COLLECT && cnt_reg != '0)
        frame_err_next = 1'b1;
      word_next = assembled;
      if (bus.enc_last) begin
        push       = 1'b1;
        push_last  = 1'b1;
        state_next = IDLE;
        cnt_next   = '0;
        ecc_next   = 1'b0;
      end else if (word_full) begin
        push       = 1'b1;
        state_next = COLLECT;
        cnt_next   = '0;
        ecc_next   = 1'b0;
      end else begin
        state_next = COLLECT;
        cnt_next   = k + CW'(1);
        ecc_next   = cur_ecc;
      end
    end
  end

  // Output FIFO: entries are {last, ecc, data}.
  logic [EW-1:0]   mem [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr_reg, rd_ptr_reg;
  logic [CNTW-1:0] count_reg, count_next;
  logic            overflow_reg, hold_reg;
  logic            pop, fifo_full, wr_en;

  assign pop       = (count_reg != '0) & bus.out_ready;
  assign fifo_full = (count_reg == CNTW'(FIFO_DEPTH));
  // A pop in the same cycle frees the slot, so a full FIFO still accepts the push.
  assign wr_en     = push & (~fifo_full | pop);

  always_comb begin
    count_next = count_reg;
    case ({wr_en, pop})
      2'b10:   count_next = count_reg + CNTW'(1);
      2'b01:   count_next = count_reg - CNTW'(1);
      default: count_next = count_reg;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      count_reg    <= '0;
      overflow_reg <= 1'b0;
      hold_reg     <= 1'b0;
    end else begin
      if (wr_en) wr_ptr_reg <= wr_ptr_reg + AW'(1);
      if (pop)   rd_ptr_reg <= rd_ptr_reg + AW'(1);
      count_reg    <= count_next;
      overflow_reg <= overflow_reg | (push & fifo_full & ~pop);
      hold_reg     <= (count_next >= CNTW'(FIFO_DEPTH - 1));
    end
  end

  generate
    for (gi = 0; gi < FIFO_DEPTH; gi++) begin : g_mem
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
          mem[gi] <= '0;
        else if (wr_en && wr_ptr_reg == AW'(gi))
          mem[gi] <= {push_last, cur_ecc, assembled};
      end
    end
  endgenerate

  assign bus.out_data  = mem[rd_ptr_reg][BUS_WIDTH-1:0];
  assign bus.out_ecc   = mem[rd_ptr_reg][BUS_WIDTH];
  assign bus.out_last  = mem[rd_ptr_reg][BUS_WIDTH+1];
  assign bus.out_valid = (count_reg != '0);
  assign bus.hold      = hold_reg;
  assign bus.overflow  = overflow_reg;
  assign bus.frame_err = frame_err_reg;
endmodule
